z80_bus_ctrl: RTL and testbench

//  Bus controller between the T80s sound Z80 core and the NeoGeo sound subsystem.

---
 rtl/z80_bus_pkg.sv | 27 ++
 rtl/z80_cen_gen.sv | 25 ++
 rtl/z80_bus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_z80_bus_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types and defaults for the NeoGeo sound Z80 bus controller.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    IOW  = 2'd2,
    HOLD = 2'd3
  } bus_state_t;

  localparam int unsigned DEF_CEN_DIV      = 6;
  localparam int unsigned DEF_IO_WAIT      = 1;
  localparam int unsigned DEF_TIMEOUT      = 255;
  localparam logic [7:0]  DEF_CMD_PORT     = 8'h00;
  localparam logic [7:0]  DEF_NMI_EN_PORT  = 8'h08;
  localparam logic [7:0]  DEF_NMI_DIS_PORT = 8'h18;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DIV_W     = cnt_w(DEF_CEN_DIV);
  localparam int unsigned TIMEOUT_W = cnt_w(DEF_TIMEOUT);
  localparam int unsigned IO_WAIT_W = 4;

endpackage

// File: rtl/z80_cen_gen.sv
// Free-running divider producing the Z80 T-state clock enable (one pulse per CEN_DIV clocks).
module z80_cen_gen
  import z80_bus_pkg::*;
#(
  parameter int unsigned CEN_DIV = DEF_CEN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic cen
);

  localparam int unsigned W    = cnt_w(CEN_DIV);
  localparam logic [W-1:0] LAST = W'(CEN_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign cen = (cnt == LAST);

endmodule

// File: rtl/z80_bus_ctrl.sv
// Sound Z80 bus controller: CEN generation, memory req/ack handshake, IO wait states, command NMI.
// Optional memory-request timeout with sticky BUS_ERR when Z80_BUS_TIMEOUT_EN is defined.
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter int unsigned CEN_DIV      = DEF_CEN_DIV,
  parameter int unsigned IO_WAIT      = DEF_IO_WAIT,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter logic [7:0]  CMD_PORT     = DEF_CMD_PORT,
  parameter logic [7:0]  NMI_EN_PORT  = DEF_NMI_EN_PORT,
  parameter logic [7:0]  NMI_DIS_PORT = DEF_NMI_DIS_PORT
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  output logic        CEN,
  input  logic [15:0] Z_A,
  input  logic [7:0]  Z_DO,
  output logic [7:0]  Z_DI,
  input  logic        Z_nMREQ,
  input  logic        Z_nIORQ,
  input  logic        Z_nRD,
  input  logic        Z_nWR,
  input  logic        Z_nRFSH,
  output logic        Z_nWAIT,
  output logic        Z_nNMI,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  input  logic        MEM_ACK,
  input  logic [7:0]  IO_RDATA,
  input  logic [7:0]  SND_CMD,
  input  logic        SND_CMD_WR,
  output logic        BUS_ERR
);

  localparam logic [IO_WAIT_W-1:0] IO_WAIT_INIT = IO_WAIT_W'(IO_WAIT);

  bus_state_t           state;
  logic [IO_WAIT_W-1:0] io_cnt;
  logic                 io_wr_q;
  logic                 io_cmd_q;
  logic                 nmi_en;
  logic                 nmi_pend;

  logic mem_start, io_start, io_wr, io_cmd_rd, pend_clr;

  z80_cen_gen #(.CEN_DIV(CEN_DIV)) u_cen (
    .clk   (CLK_24M),
    .rst_n (nRESET),
    .cen   (CEN)
  );

  // IORQ without RD/WR is an interrupt acknowledge: handled as a plain read of IO_RDATA.
  assign mem_start = !Z_nMREQ && Z_nRFSH && (!Z_nRD || !Z_nWR);
  assign io_start  = !Z_nIORQ;
  assign io_wr     = !Z_nWR;
  assign io_cmd_rd = !Z_nRD && (Z_A[7:0] == CMD_PORT);
  assign pend_clr  = (state == IDLE) && CEN && !mem_start && io_start && io_cmd_rd;

  assign Z_nNMI = !(nmi_pend && nmi_en);

`ifdef Z80_BUS_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_w(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign BUS_ERR = 1'b0;
`endif

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      Z_DI      <= 8'hFF;
      Z_nWAIT   <= 1'b1;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      io_cnt    <= '0;
      io_wr_q   <= 1'b0;
      io_cmd_q  <= 1'b0;
      nmi_en    <= 1'b0;
      nmi_pend  <= 1'b0;
`ifdef Z80_BUS_TIMEOUT_EN
      to_cnt    <= '0;
      BUS_ERR   <= 1'b0;
`endif
    end else begin
      // A new command arriving in the clearing cycle must not be lost.
      if (SND_CMD_WR)    nmi_pend <= 1'b1;
      else if (pend_clr) nmi_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (CEN && mem_start) begin
            state     <= MEM;
            MEM_REQ   <= 1'b1;
            MEM_WE    <= !Z_nWR;
            MEM_ADDR  <= Z_A;
            MEM_WDATA <= Z_DO;
            Z_nWAIT   <= 1'b0;
`ifdef Z80_BUS_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end else if (CEN && io_start) begin
            io_wr_q  <= io_wr;
            io_cmd_q <= io_cmd_rd;
            if (io_wr && Z_A[7:0] == NMI_EN_PORT)  nmi_en <= 1'b1;
            if (io_wr && Z_A[7:0] == NMI_DIS_PORT) nmi_en <= 1'b0;
            if (IO_WAIT == 0) begin
              state <= HOLD;
              if (!io_wr) Z_DI <= io_cmd_rd ? SND_CMD : IO_RDATA;
            end else begin
              state   <= IOW;
              Z_nWAIT <= 1'b0;
              io_cnt  <= IO_WAIT_INIT;
            end
          end
        end

        MEM: begin
          if (MEM_ACK) begin
            state   <= HOLD;
            MEM_REQ <= 1'b0;
            Z_nWAIT <= 1'b1;
            if (!MEM_WE) Z_DI <= MEM_RDATA;
          end
`ifdef Z80_BUS_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state   <= HOLD;
            MEM_REQ <= 1'b0;
            Z_nWAIT <= 1'b1;
            Z_DI    <= 8'hFF;
            BUS_ERR <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        IOW: begin
          if (CEN) begin
            if (io_cnt == IO_WAIT_W'(1)) begin
              state   <= HOLD;
              Z_nWAIT <= 1'b1;
              if (!io_wr_q) Z_DI <= io_cmd_q ? SND_CMD : IO_RDATA;
            end else begin
              io_cnt <= io_cnt - 1'b1;
            end
          end
        end

        HOLD: begin
          if (Z_nMREQ && Z_nIORQ) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Directed self-checking bench for z80_bus_ctrl (CEN_DIV=6, IO_WAIT=2, TIMEOUT=255).
module tb_z80_bus_ctrl;

  logic        CLK_24M = 1'b0;
  logic        nRESET  = 1'b0;
  logic        CEN;
  logic [15:0] Z_A     = '0;
  logic [7:0]  Z_DO    = '0;
  logic [7:0]  Z_DI;
  logic        Z_nMREQ = 1'b1;
  logic        Z_nIORQ = 1'b1;
  logic        Z_nRD   = 1'b1;
  logic        Z_nWR   = 1'b1;
  logic        Z_nRFSH = 1'b1;
  logic        Z_nWAIT;
  logic        Z_nNMI;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA  = '0;
  logic        MEM_ACK    = 1'b0;
  logic [7:0]  IO_RDATA   = 8'h5A;
  logic [7:0]  SND_CMD    = 8'hC3;
  logic        SND_CMD_WR = 1'b0;
  logic        BUS_ERR;

  int errors = 0;
  int checks = 0;

  z80_bus_ctrl #(
    .CEN_DIV      (6),
    .IO_WAIT      (2),
    .TIMEOUT      (255),
    .CMD_PORT     (8'h00),
    .NMI_EN_PORT  (8'h08),
    .NMI_DIS_PORT (8'h18)
  ) dut (
    .CLK_24M    (CLK_24M),
    .nRESET     (nRESET),
    .CEN        (CEN),
    .Z_A        (Z_A),
    .Z_DO       (Z_DO),
    .Z_DI       (Z_DI),
    .Z_nMREQ    (Z_nMREQ),
    .Z_nIORQ    (Z_nIORQ),
    .Z_nRD      (Z_nRD),
    .Z_nWR      (Z_nWR),
    .Z_nRFSH    (Z_nRFSH),
    .Z_nWAIT    (Z_nWAIT),
    .Z_nNMI     (Z_nNMI),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_ACK    (MEM_ACK),
    .IO_RDATA   (IO_RDATA),
    .SND_CMD    (SND_CMD),
    .SND_CMD_WR (SND_CMD_WR),
    .BUS_ERR    (BUS_ERR)
  );

  always #5 CLK_24M = ~CLK_24M;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  task automatic release_bus();
    Z_nMREQ = 1'b1; Z_nIORQ = 1'b1; Z_nRD = 1'b1; Z_nWR = 1'b1; Z_nRFSH = 1'b1;
    repeat (2) @(negedge CLK_24M);
  endtask

  task automatic wait_cen();
    int n = 0;
    while (CEN !== 1'b1 && n < 10) begin @(negedge CLK_24M); n++; end
  endtask

  task automatic wait_mem_req(output bit ok);
    int n = 0;
    while (MEM_REQ !== 1'b1 && n < 20) begin @(negedge CLK_24M); n++; end
    ok = (MEM_REQ === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mem_req_start: got MEM_REQ=%b expected 1 within 20 clocks", MEM_REQ);
    end
  endtask

  task automatic do_io(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                       input logic with_cmd_wr);
    int  n = 0;
    bit  saw_low = 0;
    if (with_cmd_wr) wait_cen();
    Z_A = addr; Z_DO = wdata; Z_nIORQ = 1'b0;
    if (wr) Z_nWR = 1'b0; else Z_nRD = 1'b0;
    if (with_cmd_wr) begin
      SND_CMD_WR = 1'b1;
      @(negedge CLK_24M);
      SND_CMD_WR = 1'b0;
    end
    while (Z_nWAIT !== 1'b0 && n < 20) begin @(negedge CLK_24M); n++; end
    saw_low = (Z_nWAIT === 1'b0);
    while (Z_nWAIT !== 1'b1 && n < 60) begin @(negedge CLK_24M); n++; end
    checks++;
    if (!saw_low || Z_nWAIT !== 1'b1) begin
      errors++;
      $display("FAIL io_handshake addr=%h: got saw_low=%b Z_nWAIT=%b expected low then high",
               addr, saw_low, Z_nWAIT);
    end
    release_bus();
  endtask

  task automatic pulse_cmd(input logic [7:0] c);
    SND_CMD = c; SND_CMD_WR = 1'b1;
    @(negedge CLK_24M);
    SND_CMD_WR = 1'b0;
    @(negedge CLK_24M);
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    repeat (3) @(negedge CLK_24M);
    checks++;
    if ({CEN, Z_nWAIT, Z_nNMI, Z_DI} !== {1'b0, 1'b1, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL reset_core: got CEN=%b nWAIT=%b nNMI=%b DI=%h expected 0 1 1 ff",
               CEN, Z_nWAIT, Z_nNMI, Z_DI);
    end
    checks++;
    if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mem: got REQ=%b WE=%b ADDR=%h WDATA=%h ERR=%b expected all 0",
               MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR);
    end
    nRESET = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      checks++;
      if (CEN !== 1'(k % 6 == 0)) begin
        errors++;
        $display("FAIL cen_clock%0d: got %b expected %b", k, CEN, (k % 6 == 0));
      end
      @(negedge CLK_24M);
    end
  endtask

  task automatic test_mem_read();
    bit ok;
    int hi = 1;
    bit wait_low = 1;
    Z_A = 16'h1234; Z_nMREQ = 1'b0; Z_nRD = 1'b0;
    wait_mem_req(ok);
    if (ok) begin
      checks++;
      if ({Z_nWAIT, MEM_WE, MEM_ADDR} !== {1'b0, 1'b0, 16'h1234}) begin
        errors++;
        $display("FAIL mem_rd_start: got nWAIT=%b WE=%b ADDR=%h expected 0 0 1234",
                 Z_nWAIT, MEM_WE, MEM_ADDR);
      end
      repeat (4) begin
        @(negedge CLK_24M);
        if (MEM_REQ === 1'b1) hi++;
        if (Z_nWAIT !== 1'b0) wait_low = 0;
      end
      MEM_RDATA = 8'hA5; MEM_ACK = 1'b1;
      @(negedge CLK_24M);
      MEM_ACK = 1'b0; MEM_RDATA = 8'h00;
      checks++;
      if (hi != 5 || !wait_low) begin
        errors++;
        $display("FAIL mem_rd_len: got req_clocks=%0d wait_low=%b expected 5 1", hi, wait_low);
      end
      checks++;
      if ({MEM_REQ, Z_nWAIT, Z_DI} !== {1'b0, 1'b1, 8'hA5}) begin
        errors++;
        $display("FAIL mem_rd_done: got REQ=%b nWAIT=%b DI=%h expected 0 1 a5",
                 MEM_REQ, Z_nWAIT, Z_DI);
      end
    end
    release_bus();
  endtask

  task automatic test_mem_write();
    bit ok;
    Z_A = 16'h8000; Z_DO = 8'h55; Z_nMREQ = 1'b0; Z_nWR = 1'b0;
    wait_mem_req(ok);
    if (ok) begin
      checks++;
      if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 16'h8000, 8'h55}) begin
        errors++;
        $display("FAIL mem_wr_start: got WE=%b ADDR=%h WDATA=%h expected 1 8000 55",
                 MEM_WE, MEM_ADDR, MEM_WDATA);
      end
      MEM_RDATA = 8'h77; MEM_ACK = 1'b1;
      @(negedge CLK_24M);
      MEM_ACK = 1'b0;
      checks++;
      if ({MEM_REQ, Z_nWAIT, Z_DI} !== {1'b0, 1'b1, 8'hA5}) begin
        errors++;
        $display("FAIL mem_wr_done: got REQ=%b nWAIT=%b DI=%h expected 0 1 a5 (write keeps DI)",
                 MEM_REQ, Z_nWAIT, Z_DI);
      end
    end
    release_bus();
  endtask

  task automatic test_refresh();
    bit req_seen = 0;
    bit wait_seen = 0;
    Z_A = 16'h0055; Z_nMREQ = 1'b0; Z_nRFSH = 1'b0; Z_nRD = 1'b0;
    repeat (14) begin
      @(negedge CLK_24M);
      if (MEM_REQ !== 1'b0) req_seen = 1;
      if (Z_nWAIT !== 1'b1) wait_seen = 1;
    end
    checks++;
    if (req_seen || wait_seen) begin
      errors++;
      $display("FAIL refresh: got req_seen=%b wait_seen=%b expected 0 0", req_seen, wait_seen);
    end
    release_bus();
  endtask

  task automatic test_io_wait();
    int n = 0;
    int low = 0;
    IO_RDATA = 8'h5A; SND_CMD = 8'hC3;
    Z_A = 16'h0004; Z_nIORQ = 1'b0; Z_nRD = 1'b0;
    while (Z_nWAIT !== 1'b0 && n < 20) begin @(negedge CLK_24M); n++; end
    while (Z_nWAIT === 1'b0 && low < 60) begin @(negedge CLK_24M); low++; end
    checks++;
    if (low != 12) begin
      errors++;
      $display("FAIL io_wait_len: got %0d clocks low expected 12", low);
    end
    checks++;
    if (Z_DI !== 8'h5A) begin
      errors++;
      $display("FAIL io_rd_data: got %h expected 5a", Z_DI);
    end
    release_bus();
  endtask

  task automatic test_nmi();
    do_io(16'h0008, 1'b1, 8'h00, 1'b0);
    checks++;
    if (Z_nNMI !== 1'b1) begin
      errors++;
      $display("FAIL nmi_idle: got %b expected 1", Z_nNMI);
    end
    pulse_cmd(8'h3C);
    checks++;
    if (Z_nNMI !== 1'b0) begin
      errors++;
      $display("FAIL nmi_assert: got %b expected 0", Z_nNMI);
    end
    do_io(16'h0000, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({Z_DI, Z_nNMI} !== {8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL cmd_read: got DI=%h nNMI=%b expected 3c 1", Z_DI, Z_nNMI);
    end
    do_io(16'h0018, 1'b1, 8'h00, 1'b0);
    pulse_cmd(8'h42);
    repeat (3) @(negedge CLK_24M);
    checks++;
    if (Z_nNMI !== 1'b1) begin
      errors++;
      $display("FAIL nmi_disabled: got %b expected 1", Z_nNMI);
    end
    do_io(16'h0008, 1'b1, 8'h00, 1'b0);
    checks++;
    if (Z_nNMI !== 1'b0) begin
      errors++;
      $display("FAIL nmi_enable_pending: got %b expected 0", Z_nNMI);
    end
    do_io(16'h0000, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({Z_DI, Z_nNMI} !== {8'h42, 1'b0}) begin
      errors++;
      $display("FAIL set_wins_clear: got DI=%h nNMI=%b expected 42 0", Z_DI, Z_nNMI);
    end
    do_io(16'h0000, 1'b0, 8'h00, 1'b0);
    checks++;
    if (Z_nNMI !== 1'b1) begin
      errors++;
      $display("FAIL nmi_final_clear: got %b expected 1", Z_nNMI);
    end
  endtask

  task automatic test_timeout();
`ifdef Z80_BUS_TIMEOUT_EN
    bit ok;
    int hi = 1;
    Z_A = 16'h4000; Z_nMREQ = 1'b0; Z_nRD = 1'b0;
    wait_mem_req(ok);
    if (ok) begin
      while (MEM_REQ === 1'b1 && hi < 400) begin
        @(negedge CLK_24M);
        if (MEM_REQ === 1'b1) hi++;
      end
      checks++;
      if (hi != 255) begin
        errors++;
        $display("FAIL timeout_len: got %0d clocks expected 255", hi);
      end
      checks++;
      if ({MEM_REQ, Z_DI, BUS_ERR, Z_nWAIT} !== {1'b0, 8'hFF, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL timeout_state: got REQ=%b DI=%h ERR=%b nWAIT=%b expected 0 ff 1 1",
                 MEM_REQ, Z_DI, BUS_ERR, Z_nWAIT);
      end
    end
    release_bus();
`else
    checks++;
    if (BUS_ERR !== 1'b0) begin
      errors++;
      $display("FAIL bus_err_tied: got %b expected 0", BUS_ERR);
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    do_io(16'h0008, 1'b1, 8'h00, 1'b0);
    Z_A = 16'h2222; Z_nMREQ = 1'b0; Z_nRD = 1'b0;
    wait_mem_req(ok);
    nRESET = 1'b0;
    #1;
    checks++;
    if ({MEM_REQ, Z_nWAIT} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got REQ=%b nWAIT=%b expected 0 1", MEM_REQ, Z_nWAIT);
    end
    release_bus();
    nRESET = 1'b1;
    @(negedge CLK_24M);
    MEM_RDATA = 8'h11; MEM_ACK = 1'b1;
    @(negedge CLK_24M);
    MEM_ACK = 1'b0;
    @(negedge CLK_24M);
    checks++;
    if ({MEM_REQ, Z_nWAIT, Z_DI, BUS_ERR, Z_nNMI} !== {1'b0, 1'b1, 8'hFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL stray_ack: got REQ=%b nWAIT=%b DI=%h ERR=%b nNMI=%b expected 0 1 ff 0 1",
               MEM_REQ, Z_nWAIT, Z_DI, BUS_ERR, Z_nNMI);
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_refresh();
    test_io_wait();
    test_nmi();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
